// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and op classification helpers for the mul/div sequencer.
package muldiv_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0, MULT, MULTU, MUL, MADD, MADDU, MSUB, MSUBU, DIV, DIVU, MTHI, MTLO
  } md_op_t;

  typedef enum logic [2:0] {IDLE, MUL_WAIT, ACC, DIV_WAIT, DONE} md_state_t;

  function automatic logic is_signed(input md_op_t op);
    return op inside {MULT, MUL, MADD, MSUB, DIV};
  endfunction

  function automatic logic is_acc(input md_op_t op);
    return op inside {MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_sub(input md_op_t op);
    return op inside {MSUB, MSUBU};
  endfunction

  function automatic logic is_mul(input md_op_t op);
    return op inside {MULT, MULTU, MUL, MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_div(input md_op_t op);
    return op inside {DIV, DIVU};
  endfunction

  function automatic logic writes_hilo(input md_op_t op);
    return !(op inside {NOP, MUL});
  endfunction

endpackage

// File: rtl/muldiv_hilo.sv
// Architectural HI/LO registers plus the 64-bit madd/msub accumulate adder.
module muldiv_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] d_hi,
  input  logic [31:0] d_lo,
  input  logic [63:0] acc_p,
  input  logic        acc_sub,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic [63:0] acc_res
);

  assign acc_res = acc_sub ? ({hi_q, lo_q} - acc_p) : ({hi_q, lo_q} + acc_p);

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (we_hi) hi_q <= d_hi;
      if (we_lo) lo_q <= d_lo;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage mul/div sequencer: drives the external multiplier/divider and owns HI/LO.
// Optional MULDIV_DIVZERO_FAST_EN: divide by zero bypasses the divider (HI=src1, LO=all ones).
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_TMO = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        ex_stall,
  output logic        resp_valid,
  output logic [31:0] resp_gpr,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p,
  output logic        div_start,
  output logic        div_abort,
  output logic [31:0] div_dvd,
  output logic [31:0] div_dvs,
  input  logic        div_done,
  input  logic [31:0] div_quo,
  input  logic [31:0] div_rem
);

  localparam int CW = $clog2((MUL_LAT > DIV_TMO ? MUL_LAT : DIV_TMO) + 1);

  md_state_t     state, state_n;
  md_op_t        op, op_q;
  logic [CW-1:0] cnt;
  logic          neg, qneg, rneg, fast_q, dz_fast, sgn;
  logic [31:0]   mag1, mag2;
  logic [63:0]   res_q, acc_res;
  logic          we_hi, we_lo, start_n, abort_n;
  logic [31:0]   d_hi, d_lo;

  assign op   = md_op_t'(req_op);
  assign sgn  = is_signed(op);
  assign mag1 = (sgn && req_src1[31]) ? -req_src1 : req_src1;
  assign mag2 = (sgn && req_src2[31]) ? -req_src2 : req_src2;

`ifdef MULDIV_DIVZERO_FAST_EN
  assign dz_fast = (req_src2 == 32'd0);
`else
  assign dz_fast = 1'b0;
`endif

  assign resp_valid = (state == DONE) && !flush;
  assign resp_gpr   = (state == DONE && op_q == MUL) ? res_q[31:0] : '0;
  assign ex_stall   = req_valid && !resp_valid;

  always_comb begin
    state_n = state;
    start_n = 1'b0;
    abort_n = 1'b0;
    we_hi   = 1'b0;
    we_lo   = 1'b0;
    d_hi    = req_src1;
    d_lo    = req_src1;
    case (state)
      IDLE: if (req_valid) begin
        if (op == MTHI) begin
          we_hi   = 1'b1;
          state_n = DONE;
        end else if (op == MTLO) begin
          we_lo   = 1'b1;
          state_n = DONE;
        end else if (is_mul(op)) begin
          state_n = MUL_WAIT;
        end else if (is_div(op)) begin
          start_n = !dz_fast;
          state_n = DIV_WAIT;
        end
      end
      MUL_WAIT: if (cnt == '0) state_n = is_acc(op_q) ? ACC : DONE;
      ACC:      state_n = DONE;
      DIV_WAIT: begin
        if (fast_q || div_done) begin
          state_n = DONE;
        end else if (cnt == CW'(DIV_TMO - 1)) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end
      end
      DONE: begin
        state_n = IDLE;
        // MTHI/MTLO already wrote in IDLE; MUL only returns a GPR value.
        if ((is_mul(op_q) || is_div(op_q)) && writes_hilo(op_q)) begin
          we_hi = 1'b1;
          we_lo = 1'b1;
          d_hi  = res_q[63:32];
          d_lo  = res_q[31:0];
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      we_hi   = 1'b0;
      we_lo   = 1'b0;
      start_n = 1'b0;
      abort_n = (state == DIV_WAIT) && !fast_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= NOP;
      cnt       <= '0;
      neg       <= 1'b0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      fast_q    <= 1'b0;
      res_q     <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      div_dvd   <= '0;
      div_dvs   <= '0;
      div_start <= 1'b0;
      div_abort <= 1'b0;
    end else begin
      div_start <= start_n;
      div_abort <= abort_n;
      case (state)
        IDLE: if (req_valid) begin
          op_q   <= op;
          neg    <= sgn && (req_src1[31] ^ req_src2[31]);
          qneg   <= sgn && (req_src1[31] ^ req_src2[31]);
          rneg   <= sgn && req_src1[31];
          fast_q <= dz_fast;
          if (is_mul(op)) begin
            mul_a <= mag1;
            mul_b <= mag2;
            cnt   <= CW'(MUL_LAT);
          end
          if (is_div(op)) begin
            div_dvd <= mag1;
            div_dvs <= mag2;
            cnt     <= '0;
            if (dz_fast) res_q <= {req_src1, 32'hFFFF_FFFF};
          end
        end
        MUL_WAIT: begin
          if (cnt == '0) res_q <= neg ? -mul_p : mul_p;
          else           cnt   <= cnt - CW'(1);
        end
        ACC: res_q <= acc_res;
        DIV_WAIT: if (!fast_q) begin
          // Watchdog counts cycles spent waiting on the divider.
          cnt <= cnt + CW'(1);
          if (div_done) res_q <= {rneg ? -div_rem : div_rem, qneg ? -div_quo : div_quo};
        end
        default: ;
      endcase
    end
  end

  muldiv_hilo u_hilo (
    .clk     (clk),
    .reset   (reset),
    .we_hi   (we_hi),
    .we_lo   (we_lo),
    .d_hi    (d_hi),
    .d_lo    (d_lo),
    .acc_p   (res_q),
    .acc_sub (is_sub(op_q)),
    .hi_q    (hi_q),
    .lo_q    (lo_q),
    .acc_res (acc_res)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl with behavioural multiplier/divider and an expected-result queue.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int DIV_TMO = 40;

  logic        clk = 1'b0;
  logic        reset, req_valid, flush;
  logic [3:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        ex_stall, resp_valid;
  logic [31:0] resp_gpr, hi_q, lo_q, mul_a, mul_b;
  logic [63:0] mul_p;
  logic        div_start, div_abort, div_done;
  logic [31:0] div_dvd, div_dvs, div_quo, div_rem;

  int checks = 0, failures = 0;
  int n_resp = 0, n_start = 0, n_abort = 0;
  int div_lat = 33;
  logic [31:0] m_hi = '0, m_lo = '0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] gpr;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_TMO(DIV_TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush), .ex_stall(ex_stall),
    .resp_valid(resp_valid), .resp_gpr(resp_gpr), .hi_q(hi_q), .lo_q(lo_q),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .div_start(div_start),
    .div_abort(div_abort), .div_dvd(div_dvd), .div_dvs(div_dvs), .div_done(div_done),
    .div_quo(div_quo), .div_rem(div_rem)
  );

  // Unsigned pipelined multiplier: operands sampled at an edge, product MUL_LAT edges later.
  logic [63:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[MUL_LAT-1];

  // Iterative divider: done pulses div_lat cycles after the start pulse.
  logic        d_busy = 1'b0;
  int          d_cnt = 0;
  always @(posedge clk) begin
    div_done <= 1'b0;
    if (reset || div_abort) d_busy <= 1'b0;
    else if (div_start) begin
      d_busy  <= 1'b1;
      d_cnt   <= div_lat - 1;
      div_quo <= (div_dvs == 0) ? 32'hFFFF_FFFF : div_dvd / div_dvs;
      div_rem <= (div_dvs == 0) ? div_dvd : div_dvd % div_dvs;
    end else if (d_busy) begin
      if (d_cnt == 1) begin
        div_done <= 1'b1;
        d_busy   <= 1'b0;
      end else d_cnt <= d_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (resp_valid) n_resp  <= n_resp + 1;
    if (div_start)  n_start <= n_start + 1;
    if (div_abort)  n_abort <= n_abort + 1;
  end

  function automatic exp_t model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    logic signed [63:0] sa, sb64;
    logic [63:0] p, cur;
    logic signed [31:0] a32, b32;
    e.hi = hi; e.lo = lo; e.gpr = '0; e.lat = 0;
    sa = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    p = (op inside {MULT, MUL, MADD, MSUB}) ? 64'(sa * sb64) : {32'b0, a} * {32'b0, b};
    cur = {hi, lo};
    a32 = a; b32 = b;
    case (op)
      MULT, MULTU:  {e.hi, e.lo} = p;
      MUL:          e.gpr = p[31:0];
      MADD, MADDU:  {e.hi, e.lo} = cur + p;
      MSUB, MSUBU:  {e.hi, e.lo} = cur - p;
      DIV: if (b == 0) {e.hi, e.lo} = {a, 32'hFFFF_FFFF};
           else begin e.lo = a32 / b32; e.hi = a32 % b32; end
      DIVU: if (b == 0) {e.hi, e.lo} = {a, 32'hFFFF_FFFF};
            else begin e.lo = a / b; e.hi = a % b; end
      MTHI: e.hi = a;
      MTLO: e.lo = a;
      default: ;
    endcase
    return e;
  endfunction

  // Presents one request, holds it until resp_valid, and releases it after that edge.
  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] gpr, output logic ok);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    lat = 0; gpr = '0; ok = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = i; gpr = resp_gpr; ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (hi_q !== 32'd0 || lo_q !== 32'd0) begin
      failures++; $display("FAIL reset_hilo got=%h_%h exp=0_0", hi_q, lo_q);
    end
    checks++;
    if ({resp_valid, div_start, div_abort, ex_stall} !== 4'b0) begin
      failures++; $display("FAIL reset_ctl got=%b exp=0000", {resp_valid, div_start, div_abort, ex_stall});
    end
    checks++;
    if (mul_a !== 32'd0 || mul_b !== 32'd0) begin
      failures++; $display("FAIL reset_mul_ab got=%h,%h exp=0,0", mul_a, mul_b);
    end
  endtask

  task automatic test_mul();
    md_op_t      ops[5] = '{MULT, MULTU, MUL, MUL, MULT};
    logic [31:0] as[5]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFD, 32'h8000_0000};
    logic [31:0] bs[5]  = '{32'd5, 32'hFFFF_FFFF, 32'h0001_0000, 32'd5, 32'hFFFF_FFFF};
    exp_t e; int lat; logic [31:0] gpr; logic ok;
    for (int i = 0; i < 5; i++) begin
      e = model(ops[i], as[i], bs[i], m_hi, m_lo);
      e.lat = MUL_LAT + 2;
      sb.push_back(e);
      issue(ops[i], as[i], bs[i], lat, gpr, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != e.lat) begin failures++; $display("FAIL mul%0d_latency got=%0d exp=%0d", i, lat, e.lat); end
      checks++;
      if (gpr !== e.gpr) begin failures++; $display("FAIL mul%0d_gpr got=%h exp=%h", i, gpr, e.gpr); end
      checks++;
      if (hi_q !== e.hi || lo_q !== e.lo) begin
        failures++; $display("FAIL mul%0d_hilo got=%h_%h exp=%h_%h", i, hi_q, lo_q, e.hi, e.lo);
      end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic test_acc();
    md_op_t      ops[6] = '{MTHI, MTLO, MADDU, MSUB, MADD, MSUBU};
    logic [31:0] as[6]  = '{32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] bs[6]  = '{32'd0, 32'd0, 32'd2, 32'd1, 32'd3, 32'h10};
    exp_t e; int lat; logic [31:0] gpr; logic ok;
    for (int i = 0; i < 6; i++) begin
      e = model(ops[i], as[i], bs[i], m_hi, m_lo);
      e.lat = (ops[i] inside {MTHI, MTLO}) ? 1 : MUL_LAT + 3;
      sb.push_back(e);
      issue(ops[i], as[i], bs[i], lat, gpr, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != e.lat) begin failures++; $display("FAIL acc%0d_latency got=%0d exp=%0d", i, lat, e.lat); end
      checks++;
      if (hi_q !== e.hi || lo_q !== e.lo) begin
        failures++; $display("FAIL acc%0d_hilo got=%h_%h exp=%h_%h", i, hi_q, lo_q, e.hi, e.lo);
      end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic test_div();
    md_op_t      ops[5] = '{DIV, DIVU, DIV, DIV, DIVU};
    logic [31:0] as[5]  = '{32'hFFFF_FFF9, 32'd7, 32'd7, 32'd5, 32'h8000_0000};
    logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd3};
    exp_t e; int lat, s0, exp_starts; logic [31:0] gpr; logic ok;
    for (int i = 0; i < 5; i++) begin
      e = model(ops[i], as[i], bs[i], m_hi, m_lo);
      exp_starts = 1;
      e.lat = div_lat + 2;
`ifdef MULDIV_DIVZERO_FAST_EN
      if (bs[i] == 0) begin e.lat = 2; exp_starts = 0; end
`endif
      sb.push_back(e);
      s0 = n_start;
      issue(ops[i], as[i], bs[i], lat, gpr, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != e.lat) begin failures++; $display("FAIL div%0d_latency got=%0d exp=%0d", i, lat, e.lat); end
      checks++;
      if (hi_q !== e.hi || lo_q !== e.lo) begin
        failures++; $display("FAIL div%0d_hilo got=%h_%h exp=%h_%h", i, hi_q, lo_q, e.hi, e.lo);
      end
      checks++;
      if (n_start - s0 != exp_starts) begin
        failures++; $display("FAIL div%0d_starts got=%0d exp=%0d", i, n_start - s0, exp_starts);
      end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic test_flush_mthi();
    int r0 = n_resp;
    req_valid = 1'b1; req_op = MTHI; req_src1 = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (hi_q !== m_hi || n_resp != r0) begin
      failures++; $display("FAIL flush_mthi got hi=%h resp=%0d exp hi=%h resp=0", hi_q, n_resp - r0, m_hi);
    end
  endtask

  task automatic test_flush_div();
    int r0 = n_resp, a0 = n_abort, lat; exp_t e; logic [31:0] gpr; logic ok;
    req_valid = 1'b1; req_op = DIV; req_src1 = 32'd100; req_src2 = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (div_abort !== 1'b1) begin failures++; $display("FAIL flush_div_abort got=%b exp=1", div_abort); end
    repeat (40) @(negedge clk);
    checks++;
    if (n_resp != r0 || n_abort - a0 != 1) begin
      failures++; $display("FAIL flush_div_pulses got resp=%0d abort=%0d exp resp=0 abort=1", n_resp - r0, n_abort - a0);
    end
    checks++;
    if (hi_q !== m_hi || lo_q !== m_lo) begin
      failures++; $display("FAIL flush_div_hilo got=%h_%h exp=%h_%h", hi_q, lo_q, m_hi, m_lo);
    end
    e = model(DIVU, 32'd7, 32'd2, m_hi, m_lo);
    e.lat = div_lat + 2;
    sb.push_back(e);
    issue(DIVU, 32'd7, 32'd2, lat, gpr, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.lat || hi_q !== e.hi || lo_q !== e.lo) begin
      failures++; $display("FAIL flush_div_next got lat=%0d hilo=%h_%h exp lat=%0d hilo=%h_%h",
                           lat, hi_q, lo_q, e.lat, e.hi, e.lo);
    end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic test_watchdog();
    int r0 = n_resp, abort_at = 0;
    div_lat = 100;
    req_valid = 1'b1; req_op = DIV; req_src1 = 32'd100; req_src2 = 32'd7;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (div_abort) begin abort_at = i; break; end
    end
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (abort_at != DIV_TMO + 1) begin failures++; $display("FAIL wdog_abort_cycle got=%0d exp=%0d", abort_at, DIV_TMO + 1); end
    checks++;
    if (n_resp != r0 || hi_q !== m_hi || lo_q !== m_lo) begin
      failures++; $display("FAIL wdog_nowrite got resp=%0d hilo=%h_%h exp resp=0 hilo=%h_%h",
                           n_resp - r0, hi_q, lo_q, m_hi, m_lo);
    end
    div_lat = 33;
  endtask

  task automatic test_reset_midop();
    int r0, lat; exp_t e; logic [31:0] gpr; logic ok;
    req_valid = 1'b1; req_op = MULT; req_src1 = 32'd9; req_src2 = 32'd9;
    repeat (2) @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    r0 = n_resp;
    checks++;
    if (hi_q !== 32'd0 || lo_q !== 32'd0 || mul_a !== 32'd0) begin
      failures++; $display("FAIL rst_mid_hilo got=%h_%h a=%h exp=0_0 a=0", hi_q, lo_q, mul_a);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (n_resp != r0) begin failures++; $display("FAIL rst_mid_resp got=%0d exp=0", n_resp - r0); end
    m_hi = '0; m_lo = '0;
    e = model(MTLO, 32'h1234_5678, 32'd0, m_hi, m_lo);
    e.lat = 1;
    sb.push_back(e);
    issue(MTLO, 32'h1234_5678, 32'd0, lat, gpr, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.lat || hi_q !== e.hi || lo_q !== e.lo) begin
      failures++; $display("FAIL rst_mid_next got lat=%0d hilo=%h_%h exp lat=%0d hilo=%h_%h",
                           lat, hi_q, lo_q, e.lat, e.hi, e.lo);
    end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_mul();
    test_acc();
    test_div();
    test_flush_mthi();
    test_flush_div();
    test_watchdog();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
